// File: rtl/jtag_data_registers_pkg.sv
// Shared definitions for the JTAG data-register block: instruction
// opcodes and the DR selection enum used by the decode.
package jtag_pkg;

    localparam int IR_W = 2;

    // Instruction opcodes; any code not listed here selects BYPASS.
    localparam logic [IR_W-1:0] IR_IDCODE = 2'b01;
    localparam logic [IR_W-1:0] IR_USER   = 2'b10;
    localparam logic [IR_W-1:0] IR_BYPASS = 2'b11;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_data_registers_if.sv
// TAP-side bundle for the DR block: strobes, serial data and the
// USER parallel in/out. The TAP/test side is master, the DR block is slave.
interface jtag_data_registers_if #(
    parameter int IR_WIDTH   = 2,
    parameter int USER_WIDTH = 8
);
    logic                  tdi;
    logic [IR_WIDTH-1:0]   ir;
    logic                  tlr;
    logic                  capture_dr;
    logic                  shift_dr;
    logic                  update_dr;
    logic [USER_WIDTH-1:0] user_d;
    logic                  tdo_dr;
    logic [USER_WIDTH-1:0] user_q;
    logic                  user_upd;

    modport master (
        output tdi, ir, tlr, capture_dr, shift_dr, update_dr, user_d,
        input  tdo_dr, user_q, user_upd
    );

    modport slave (
        input  tdi, ir, tlr, capture_dr, shift_dr, update_dr, user_d,
        output tdo_dr, user_q, user_upd
    );
endinterface

// File: rtl/jtag_data_registers_shift_reg.sv
// Generic capture/shift register: parallel capture, right shift with the
// serial input entering the MSB, serial output from bit 0.
module jtag_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] pdata,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    // Capture has priority over shift; the caller already gates by selection.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else if (cap_en)
            q <= pdata;
        else if (shift_en)
            q <= {si, q[WIDTH-1:1]};
    end

    assign so = q[0];

endmodule

// File: rtl/jtag_data_registers.sv
// JTAG data registers: BYPASS, IDCODE and USER selected by the latched
// instruction, with the USER update stage and the DR serial-out mux.
module jtag_data_registers
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = 2,
    parameter int                    USER_WIDTH   = 8,
    parameter logic [31:0]           IDCODE_VALUE = 32'h1A2B_3C4D,
    parameter logic [USER_WIDTH-1:0] USER_RESET   = '0
) (
    input  logic                  tck,
    input  logic                  trst,
    jtag_data_registers_if.slave  dr
);

    // Elaboration-time parameter sanity.
    generate
        if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
            $error("IDCODE_VALUE bit 0 must be 1");
        end
        if (USER_WIDTH < 2 || USER_WIDTH > 32) begin : g_bad_user_width
            $error("USER_WIDTH must be in 2..32");
        end
    endgenerate

    dr_sel_e               sel;
    logic                  cap_s, shf_s, upd_s;
    logic                  bypass_sr;
    logic [31:0]           idcode_sr;
    logic                  idcode_so;
    logic [USER_WIDTH-1:0] user_sr;
    logic                  user_so;
    logic [USER_WIDTH-1:0] user_q_r;
    logic                  user_upd_r;
    logic                  unused_idcode;

    // Instruction decode; unknown codes (including all-zero) fall to BYPASS.
    always_comb begin
        sel = DR_BYPASS;
        if (dr.ir == IR_WIDTH'(IR_IDCODE))
            sel = DR_IDCODE;
        else if (dr.ir == IR_WIDTH'(IR_USER))
            sel = DR_USER;
    end

    // Strobe priority tlr > capture > shift > update; trst is applied in the flops.
    assign cap_s = dr.capture_dr & ~dr.tlr;
    assign shf_s = dr.shift_dr & ~dr.tlr & ~dr.capture_dr;
    assign upd_s = dr.update_dr & ~dr.tlr & ~dr.capture_dr & ~dr.shift_dr;

    // One-bit BYPASS register: captures 0, shifts tdi straight in.
    always_ff @(posedge tck) begin
        if (trst)
            bypass_sr <= 1'b0;
        else if (sel == DR_BYPASS) begin
            if (cap_s)
                bypass_sr <= 1'b0;
            else if (shf_s)
                bypass_sr <= dr.tdi;
        end
    end

    jtag_shift_reg #(
        .WIDTH     (32),
        .RESET_VAL (IDCODE_VALUE)
    ) u_idcode (
        .clk      (tck),
        .rst      (trst),
        .cap_en   (cap_s & (sel == DR_IDCODE)),
        .shift_en (shf_s & (sel == DR_IDCODE)),
        .pdata    (IDCODE_VALUE),
        .si       (dr.tdi),
        .q        (idcode_sr),
        .so       (idcode_so)
    );

    // Only bit 0 of IDCODE is observed; upper bits reach TDO by shifting.
    assign unused_idcode = ^idcode_sr[31:1];

    jtag_shift_reg #(
        .WIDTH     (USER_WIDTH),
        .RESET_VAL ('0)
    ) u_user (
        .clk      (tck),
        .rst      (trst),
        .cap_en   (cap_s & (sel == DR_USER)),
        .shift_en (shf_s & (sel == DR_USER)),
        .pdata    (dr.user_d),
        .si       (dr.tdi),
        .q        (user_sr),
        .so       (user_so)
    );

    // USER update stage: reloads on update_dr and pulses user_upd for one cycle.
    always_ff @(posedge tck) begin
        if (trst || dr.tlr) begin
            user_q_r   <= USER_RESET;
            user_upd_r <= 1'b0;
        end else begin
            user_upd_r <= upd_s && (sel == DR_USER);
            if (upd_s && (sel == DR_USER))
                user_q_r <= user_sr;
        end
    end

    // Serial out of the selected register, flop outputs only.
    always_comb begin
        unique case (sel)
            DR_IDCODE: dr.tdo_dr = idcode_so;
            DR_USER:   dr.tdo_dr = user_so;
            default:   dr.tdo_dr = bypass_sr;
        endcase
    end

    assign dr.user_q   = user_q_r;
    assign dr.user_upd = user_upd_r;

endmodule

// File: tb/tb_jtag_data_registers.sv
// Directed plus random bench for jtag_data_registers. The reference model
// keeps each DR as a bit queue (front = next bit out) and applies the
// capture/shift/update rules directly to those queues.
module tb_jtag_data_registers;

    localparam int          UW   = 8;
    localparam logic [31:0] IDV  = 32'h1A2B_3C4D;
    localparam logic [UW-1:0] URST = 8'h5A;

    logic tck  = 1'b0;
    logic trst = 1'b0;
    always #5 tck = ~tck;

    jtag_data_registers_if #(.IR_WIDTH(2), .USER_WIDTH(UW)) dr();

    jtag_data_registers #(
        .IR_WIDTH     (2),
        .USER_WIDTH   (UW),
        .IDCODE_VALUE (IDV),
        .USER_RESET   (URST)
    ) dut (
        .tck  (tck),
        .trst (trst),
        .dr   (dr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          bq[$];
    bit          iq[$];
    bit          uq[$];
    logic [UW-1:0] mq;
    logic          mupd;
    logic [31:0]   idv_v = IDV;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int msel(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b10) return 2;
        return 0;
    endfunction

    function automatic logic mtdo();
        case (msel(dr.ir))
            1:       return iq[0];
            2:       return uq[0];
            default: return bq[0];
        endcase
    endfunction

    function automatic logic [UW-1:0] uval();
        logic [UW-1:0] v = '0;
        for (int i = 0; i < UW; i++) v[i] = uq[i];
        return v;
    endfunction

    task automatic model_step(input logic r, t, c, s, u, d);
        int sel = msel(dr.ir);
        logic [UW-1:0] ud = dr.user_d;
        if (r) begin
            bq.delete(); bq.push_back(1'b0);
            iq.delete(); for (int i = 0; i < 32; i++) iq.push_back(idv_v[i]);
            uq.delete(); for (int i = 0; i < UW; i++) uq.push_back(1'b0);
            mq = URST; mupd = 1'b0;
        end else if (t) begin
            mq = URST; mupd = 1'b0;
        end else begin
            mupd = 1'b0;
            if (c) begin
                case (sel)
                    1: begin iq.delete(); for (int i = 0; i < 32; i++) iq.push_back(idv_v[i]); end
                    2: begin uq.delete(); for (int i = 0; i < UW; i++) uq.push_back(ud[i]); end
                    default: begin bq.delete(); bq.push_back(1'b0); end
                endcase
            end else if (s) begin
                case (sel)
                    1: begin void'(iq.pop_front()); iq.push_back(d); end
                    2: begin void'(uq.pop_front()); uq.push_back(d); end
                    default: begin void'(bq.pop_front()); bq.push_back(d); end
                endcase
            end else if (u && sel == 2) begin
                mq = uval(); mupd = 1'b1;
            end
        end
    endtask

    // One tck cycle: drive, advance model, clock, compare all outputs.
    task automatic cyc(input string tag, input logic r, t, c, s, u, d);
        trst          = r;
        dr.tlr        = t;
        dr.capture_dr = c;
        dr.shift_dr   = s;
        dr.update_dr  = u;
        dr.tdi        = d;
        model_step(r, t, c, s, u, d);
        @(posedge tck);
        #1;
        chk({tag, "_tdo"}, 32'(dr.tdo_dr), 32'(mtdo()));
        chk({tag, "_user_q"}, 32'(dr.user_q), 32'(mq));
        chk({tag, "_user_upd"}, 32'(dr.user_upd), 32'(mupd));
    endtask

    task automatic set_ir(input logic [1:0] v);
        dr.ir = v;
        #1;
        chk("ir_switch_tdo", 32'(dr.tdo_dr), 32'(mtdo()));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic cap(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic shf(input string tag, input logic d);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic upd(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom));
    endtask

    initial begin
        logic [31:0]   word;
        logic [4:0]    bseq;
        logic [3:0]    bpat;
        logic [UW-1:0] a5;
        logic [UW-1:0] saved;

        dr.tdi = 0; dr.ir = 2'b01; dr.tlr = 0;
        dr.capture_dr = 0; dr.shift_dr = 0; dr.update_dr = 0;
        dr.user_d = '0;

        // Reset, then IDCODE read LSB-first.
        cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_tdo_idcode", 32'(dr.tdo_dr), 32'd1);
        chk("reset_user_q", 32'(dr.user_q), 32'(URST));
        chk("reset_user_upd", 32'(dr.user_upd), 32'd0);
        cap("id_cap");
        chk("id_first_bit", 32'(dr.tdo_dr), 32'd1);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            word[i] = dr.tdo_dr;
            shf("id_shift", 1'($urandom));
        end
        chk("id_word", word, IDV);

        // BYPASS one-cycle delay, with both the BYPASS code and 00.
        bpat = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            set_ir(k == 0 ? 2'b11 : 2'b00);
            cap("byp_cap");
            bseq[0] = dr.tdo_dr;
            for (int i = 0; i < 4; i++) begin
                shf("byp_shift", bpat[i]);
                bseq[i+1] = dr.tdo_dr;
            end
            chk(k == 0 ? "byp_seq_11" : "byp_seq_00", 32'(bseq), 32'(5'b11010));
        end

        // USER write of A5.
        set_ir(2'b10);
        dr.user_d = 8'($urandom);
        cap("uw_cap");
        a5 = 8'hA5;
        for (int i = 0; i < UW; i++) shf("uw_shift", a5[i]);
        upd("uw_upd");
        chk("uw_user_q", 32'(dr.user_q), 32'h0000_00A5);
        chk("uw_pulse_hi", 32'(dr.user_upd), 32'd1);
        idle("uw_idle");
        chk("uw_pulse_lo", 32'(dr.user_upd), 32'd0);

        // USER read of 3C with no update.
        dr.user_d = 8'h3C;
        cap("ur_cap");
        word = '0;
        for (int i = 0; i < UW; i++) begin
            word[i] = dr.tdo_dr;
            shf("ur_shift", 1'($urandom));
        end
        chk("ur_word", word, 32'h0000_003C);
        chk("ur_user_q_hold", 32'(dr.user_q), 32'h0000_00A5);

        // tlr mid-shift clears the update stage, shift contents hold.
        dr.user_d = 8'($urandom);
        cap("tlr_cap");
        for (int i = 0; i < 3; i++) shf("tlr_pre", 1'($urandom));
        cyc("tlr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("tlr_user_q", 32'(dr.user_q), 32'(URST));
        chk("tlr_user_upd", 32'(dr.user_upd), 32'd0);
        for (int i = 0; i < UW; i++) shf("tlr_post", 1'($urandom));

        // Capture beats update when both are asserted.
        upd("sim_load");
        saved = dr.user_q;
        dr.user_d = 8'($urandom);
        cyc("sim_cap_upd", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sim_user_q", 32'(dr.user_q), 32'(saved));
        chk("sim_user_upd", 32'(dr.user_upd), 32'd0);
        chk("sim_tdo_captured", 32'(dr.tdo_dr), 32'(dr.user_d[0]));

        // trst during shift restores every register.
        shf("rst_pre", 1'b1);
        shf("rst_pre", 1'b1);
        cyc("rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_user_q", 32'(dr.user_q), 32'(URST));
        chk("rst_mid_user_upd", 32'(dr.user_upd), 32'd0);
        chk("rst_mid_user_tdo", 32'(dr.tdo_dr), 32'd0);
        set_ir(2'b01);
        chk("rst_mid_id_tdo", 32'(dr.tdo_dr), 32'd1);
        set_ir(2'b11);
        chk("rst_mid_byp_tdo", 32'(dr.tdo_dr), 32'd0);

        // Random strobes, instructions and data against the model.
        for (int n = 0; n < 400; n++) begin
            int k;
            logic r, t, c, s, u;
            dr.ir     = 2'($urandom);
            dr.user_d = UW'($urandom);
            r = ($urandom % 60) == 0;
            t = ($urandom % 30) == 0;
            k = $urandom % 8;
            c = (k == 0); s = (k >= 1 && k <= 4); u = (k == 5);
            if (k == 7) begin
                c = 1'($urandom); s = 1'($urandom); u = 1'($urandom);
            end
            cyc("rnd", r, t, c, s, u, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
